// File: rtl/lsu_pkg.sv
// ============================================================================
// lsu_pkg : func3 codes, LSU state encoding and lane-mask helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE0 = 3'd1,
    S_WAIT0  = 3'd2,
    S_ISSUE1 = 3'd3,
    S_WAIT1  = 3'd4,
    S_RESP   = 3'd5
  } lsu_state_t;

  // Unshifted byte-lane mask for an access of the given width code.
  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: size_mask = 4'b0001;
      F3_H, F3_HU: size_mask = 4'b0011;
      default:     size_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = ~we;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic crosses_word(input logic [1:0] off, input logic [2:0] f3);
    logic [7:0] m;
    m = {4'b0000, size_mask(f3)} << off;
    crosses_word = |m[7:4];
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// lsu_align : store lane mask/shift and load extract/extend (combinational)
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_align
  import lsu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [1:0]   off_i,
  input  logic [2:0]   func3_i,
  input  logic         beat1_i,
  input  logic [N-1:0] wdata_i,
  input  logic [N-1:0] rdata_lo_i,
  input  logic [N-1:0] rdata_hi_i,
  output logic [3:0]   wsel_o,
  output logic [N-1:0] wdata_o,
  output logic [N-1:0] rdata_o
);

  logic [7:0]     w_mask8;
  logic [5:0]     w_sh0;
  logic [5:0]     w_sh1;
  logic [2*N-1:0] w_rd_cat;
  logic [N-1:0]   w_rd_sh;

  always_comb begin
    w_mask8  = {4'b0000, size_mask(func3_i)} << off_i;
    w_sh0    = {1'b0, off_i, 3'b000};
    w_sh1    = 6'd32 - w_sh0;
    // Second beat carries the bytes that spilled past the word boundary.
    if (beat1_i) begin
      wsel_o  = w_mask8[7:4];
      wdata_o = wdata_i >> w_sh1;
    end else begin
      wsel_o  = w_mask8[3:0];
      wdata_o = wdata_i << w_sh0;
    end
    w_rd_cat = {rdata_hi_i, rdata_lo_i} >> w_sh0;
    w_rd_sh  = w_rd_cat[N-1:0];
    case (func3_i)
      F3_B:    rdata_o = {{(N-8){w_rd_sh[7]}}, w_rd_sh[7:0]};
      F3_H:    rdata_o = {{(N-16){w_rd_sh[15]}}, w_rd_sh[15:0]};
      F3_BU:   rdata_o = {{(N-8){1'b0}}, w_rd_sh[7:0]};
      F3_HU:   rdata_o = {{(N-16){1'b0}}, w_rd_sh[15:0]};
      default: rdata_o = w_rd_sh;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// ============================================================================
// lsu_ctrl : single-outstanding RV32 load/store initiator (req/gnt/rvalid)
// Build option LSU_MISALIGN_EN: split word-crossing accesses into two beats.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int N  = 32,
  parameter int AW = 30
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [N-1:0]  req_addr,
  input  logic [N-1:0]  req_wdata,
  input  logic [2:0]    req_func3,
  output logic          rsp_valid,
  output logic [N-1:0]  rsp_rdata,
  output logic          rsp_fault,
  output logic          mem_req,
  input  logic          mem_gnt,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [3:0]    mem_wsel,
  output logic [N-1:0]  mem_wdata,
  input  logic          mem_rvalid,
  input  logic [N-1:0]  mem_rdata
);

  lsu_state_t   state_q, state_d;
  logic [N-1:0] addr_q, wdata_q, rlo_q, rhi_q;
  logic [2:0]   f3_q;
  logic         we_q, fault_q;

  logic         w_new_fault, w_issue, w_beat1;
  logic [3:0]   w_wsel;
  logic [N-1:0] w_wdata, w_rdata;

`ifdef LSU_MISALIGN_EN
  logic w_cross_q;
  assign w_cross_q   = crosses_word(addr_q[1:0], f3_q);
  assign w_new_fault = ~f3_legal(req_we, req_func3);
`else
  // Without split support a word-crossing access is rejected before any beat.
  assign w_new_fault = ~f3_legal(req_we, req_func3) | crosses_word(req_addr[1:0], req_func3);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rlo_q   <= '0;
      rhi_q   <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req_valid) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        f3_q    <= req_func3;
        we_q    <= req_we;
        fault_q <= w_new_fault;
      end
      if (state_q == S_WAIT0 && mem_rvalid) rlo_q <= mem_rdata;
      if (state_q == S_WAIT1 && mem_rvalid) rhi_q <= mem_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid) state_d = w_new_fault ? S_RESP : S_ISSUE0;
      S_ISSUE0: if (mem_gnt) state_d = S_WAIT0;
`ifdef LSU_MISALIGN_EN
      S_WAIT0:  if (mem_rvalid) state_d = w_cross_q ? S_ISSUE1 : S_RESP;
`else
      S_WAIT0:  if (mem_rvalid) state_d = S_RESP;
`endif
      S_ISSUE1: if (mem_gnt) state_d = S_WAIT1;
      S_WAIT1:  if (mem_rvalid) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  lsu_align #(.N(N)) u_align (
    .off_i      (addr_q[1:0]),
    .func3_i    (f3_q),
    .beat1_i    (w_beat1),
    .wdata_i    (wdata_q),
    .rdata_lo_i (rlo_q),
    .rdata_hi_i (rhi_q),
    .wsel_o     (w_wsel),
    .wdata_o    (w_wdata),
    .rdata_o    (w_rdata)
  );

  // Memory-side outputs are zero except while a beat is being offered.
  always_comb begin
    w_issue   = (state_q == S_ISSUE0) || (state_q == S_ISSUE1);
    w_beat1   = (state_q == S_ISSUE1);
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    rsp_fault = (state_q == S_RESP) && fault_q;
    rsp_rdata = (state_q == S_RESP && !we_q && !fault_q) ? w_rdata : '0;
    mem_req   = w_issue;
    mem_we    = w_issue && we_q;
    mem_waddr = w_issue ? (addr_q[N-1:2] + {{(AW-1){1'b0}}, w_beat1}) : '0;
    mem_wsel  = (w_issue && we_q) ? w_wsel : 4'b0000;
    mem_wdata = (w_issue && we_q) ? w_wdata : '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// ============================================================================
// tb_lsu_ctrl : table-driven self-checking bench for lsu_ctrl
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_func3;
  logic        rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [29:0] mem_waddr;
  logic [3:0]  mem_wsel;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  lsu_ctrl #(.N(32), .AW(30)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_func3(req_func3),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wsel(mem_wsel), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata;
    logic [2:0]  f3;
    logic [31:0] w0, w1;
    int          nb;
    logic [29:0] a0;  logic [3:0] s0;  logic [31:0] d0;
    logic [29:0] a1;  logic [3:0] s1;  logic [31:0] d1;
    logic [31:0] rd;
    logic        flt;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] f3, input logic [31:0] w0, input logic [31:0] w1,
                              input int nb, input logic [29:0] a0, input logic [3:0] s0,
                              input logic [31:0] d0, input logic [29:0] a1, input logic [3:0] s1,
                              input logic [31:0] d1, input logic [31:0] rd, input logic flt);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.f3 = f3; v.w0 = w0; v.w1 = w1;
    v.nb = nb; v.a0 = a0; v.s0 = s0; v.d0 = d0; v.a1 = a1; v.s1 = s1; v.d1 = d1;
    v.rd = rd; v.flt = flt;
    return v;
  endfunction

  task automatic issue_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_func3 = f3;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Responder: grant each offered beat at once, return rvalid the following cycle.
  task automatic run_vec(input vec_t v, input string nm);
    logic [29:0] ba[2];
    logic [3:0]  bs[2];
    logic [31:0] bd[2];
    logic        bw[2];
    int          nb;
    bit          pend, got;
    logic [31:0] rd;
    logic        flt;
    nb = 0; pend = 0; got = 0; rd = '0; flt = 1'b0;
    for (int k = 0; k < 2; k++) begin ba[k] = '0; bs[k] = '0; bd[k] = '0; bw[k] = 1'b0; end
    chk($sformatf("%s.ready", nm), {31'd0, req_ready}, 32'd1);
    issue_req(v.we, v.addr, v.wdata, v.f3);
    for (int c = 0; c < 40 && !got; c++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h5A5A_5A5A;
      if (pend) begin
        mem_rvalid = 1'b1;
        mem_rdata  = (nb == 1) ? v.w0 : v.w1;
        pend       = 0;
      end else if (mem_req) begin
        if (nb < 2) begin
          ba[nb] = mem_waddr; bs[nb] = mem_wsel; bd[nb] = mem_wdata; bw[nb] = mem_we;
        end
        nb++;
        mem_gnt = 1'b1;
        pend    = 1;
      end
      if (rsp_valid) begin
        got = 1; rd = rsp_rdata; flt = rsp_fault;
      end
      @(negedge clk);
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk($sformatf("%s.rsp_seen", nm), {31'd0, got}, 32'd1);
    chk($sformatf("%s.beats", nm), 32'(nb), 32'(v.nb));
    if (v.nb >= 1 && nb >= 1) begin
      chk($sformatf("%s.b0_addr", nm), {2'b00, ba[0]}, {2'b00, v.a0});
      chk($sformatf("%s.b0_wsel", nm), {28'd0, bs[0]}, {28'd0, v.s0});
      chk($sformatf("%s.b0_wdata", nm), bd[0], v.d0);
      chk($sformatf("%s.b0_we", nm), {31'd0, bw[0]}, {31'd0, v.we});
    end
    if (v.nb >= 2 && nb >= 2) begin
      chk($sformatf("%s.b1_addr", nm), {2'b00, ba[1]}, {2'b00, v.a1});
      chk($sformatf("%s.b1_wsel", nm), {28'd0, bs[1]}, {28'd0, v.s1});
      chk($sformatf("%s.b1_wdata", nm), bd[1], v.d1);
    end
    chk($sformatf("%s.rdata", nm), rd, v.rd);
    chk($sformatf("%s.fault", nm), {31'd0, flt}, {31'd0, v.flt});
    chk($sformatf("%s.pulse_end", nm), {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_func3 = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    //        we  addr           wdata          f3      w0             w1             nb a0            s0    d0             a1     s1    d1             rd             flt
    vt.push_back(mk(1, 32'h0000_0100, 32'hDEAD_BEEF, 3'b010, 32'h0,         32'h0,         1, 30'h40,       4'hF, 32'hDEAD_BEEF, 30'h0, 4'h0, 32'h0,         32'h0,         0));
    vt.push_back(mk(1, 32'h0000_0103, 32'h0000_00A5, 3'b000, 32'h0,         32'h0,         1, 30'h40,       4'h8, 32'hA500_0000, 30'h0, 4'h0, 32'h0,         32'h0,         0));
    vt.push_back(mk(0, 32'h0000_0102, 32'h0,         3'b000, 32'h0080_5A12, 32'h0,         1, 30'h40,       4'h0, 32'h0,         30'h0, 4'h0, 32'h0,         32'hFFFF_FF80, 0));
    vt.push_back(mk(0, 32'h0000_0102, 32'h0,         3'b100, 32'h0080_5A12, 32'h0,         1, 30'h40,       4'h0, 32'h0,         30'h0, 4'h0, 32'h0,         32'h0000_0080, 0));
    vt.push_back(mk(0, 32'h0000_0101, 32'h0,         3'b001, 32'hAB9C_8765, 32'h0,         1, 30'h40,       4'h0, 32'h0,         30'h0, 4'h0, 32'h0,         32'hFFFF_9C87, 0));
    vt.push_back(mk(0, 32'h0000_0101, 32'h0,         3'b101, 32'hAB9C_8765, 32'h0,         1, 30'h40,       4'h0, 32'h0,         30'h0, 4'h0, 32'h0,         32'h0000_9C87, 0));
    vt.push_back(mk(0, 32'h0000_0102, 32'h0,         3'b001, 32'h1234_5678, 32'h0,         1, 30'h40,       4'h0, 32'h0,         30'h0, 4'h0, 32'h0,         32'h0000_1234, 0));
    vt.push_back(mk(1, 32'h0000_0102, 32'h0000_BEEF, 3'b001, 32'h0,         32'h0,         1, 30'h40,       4'hC, 32'hBEEF_0000, 30'h0, 4'h0, 32'h0,         32'h0,         0));
    vt.push_back(mk(1, 32'h0000_0201, 32'h1234_CAFE, 3'b001, 32'h0,         32'h0,         1, 30'h80,       4'h6, 32'h34CA_FE00, 30'h0, 4'h0, 32'h0,         32'h0,         0));
    vt.push_back(mk(0, 32'h0000_0004, 32'h0,         3'b010, 32'h8000_0001, 32'h0,         1, 30'h1,        4'h0, 32'h0,         30'h0, 4'h0, 32'h0,         32'h8000_0001, 0));
    vt.push_back(mk(0, 32'h0000_0100, 32'h0,         3'b011, 32'h0,         32'h0,         0, 30'h0,        4'h0, 32'h0,         30'h0, 4'h0, 32'h0,         32'h0,         1));
    vt.push_back(mk(1, 32'h0000_0100, 32'h0000_0055, 3'b100, 32'h0,         32'h0,         0, 30'h0,        4'h0, 32'h0,         30'h0, 4'h0, 32'h0,         32'h0,         1));
`ifdef LSU_MISALIGN_EN
    vt.push_back(mk(0, 32'h0000_00FE, 32'h0,         3'b010, 32'hBBBB_1111, 32'h2222_AAAA, 2, 30'h3F,       4'h0, 32'h0,         30'h40, 4'h0, 32'h0,        32'hAAAA_BBBB, 0));
    vt.push_back(mk(1, 32'h0000_00FD, 32'h1122_3344, 3'b010, 32'h0,         32'h0,         2, 30'h3F,       4'hE, 32'h2233_4400, 30'h40, 4'h1, 32'h0000_0011, 32'h0,        0));
    vt.push_back(mk(0, 32'hFFFF_FFFF, 32'h0,         3'b001, 32'h7F00_0000, 32'h0000_0080, 2, 30'h3FFF_FFFF, 4'h0, 32'h0,        30'h0, 4'h0, 32'h0,         32'hFFFF_807F, 0));
`else
    vt.push_back(mk(0, 32'h0000_00FE, 32'h0,         3'b010, 32'hBBBB_1111, 32'h2222_AAAA, 0, 30'h0,        4'h0, 32'h0,         30'h0, 4'h0, 32'h0,         32'h0,         1));
    vt.push_back(mk(1, 32'h0000_00FD, 32'h1122_3344, 3'b010, 32'h0,         32'h0,         0, 30'h0,        4'h0, 32'h0,         30'h0, 4'h0, 32'h0,         32'h0,         1));
    vt.push_back(mk(0, 32'hFFFF_FFFF, 32'h0,         3'b001, 32'h7F00_0000, 32'h0000_0080, 0, 30'h0,        4'h0, 32'h0,         30'h0, 4'h0, 32'h0,         32'h0,         1));
`endif

    repeat (3) @(negedge clk);
    chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst.rsp_rdata", rsp_rdata, 32'd0);
    chk("rst.rsp_fault", {31'd0, rsp_fault}, 32'd0);
    chk("rst.mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst.mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst.mem_wsel", {28'd0, mem_wsel}, 32'd0);
    chk("rst.mem_waddr", {2'b00, mem_waddr}, 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vt.size(); i++) run_vec(vt[i], $sformatf("v%0d", i));

    // Grant withheld for five cycles: the offered beat must hold steady.
    issue_req(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 3'b010);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d.req", c), {31'd0, mem_req}, 32'd1);
      chk($sformatf("stall%0d.waddr", c), {2'b00, mem_waddr}, 32'h40);
      chk($sformatf("stall%0d.wsel", c), {28'd0, mem_wsel}, 32'hF);
      chk($sformatf("stall%0d.wdata", c), mem_wdata, 32'hDEAD_BEEF);
      @(negedge clk);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("stall.rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("stall.rsp_fault", {31'd0, rsp_fault}, 32'd0);
    @(negedge clk);

    // Reset while waiting for read data; the late rvalid must be ignored.
    issue_req(1'b0, 32'h0000_0010, 32'h0, 3'b010);
    chk("rstw.issue", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rstw.waiting", {31'd0, req_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstw.idle", {31'd0, req_ready}, 32'd1);
    chk("rstw.no_rsp", {31'd0, rsp_valid}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D; mem_gnt = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("rstw.late%0d.rsp", c), {31'd0, rsp_valid}, 32'd0);
      chk($sformatf("rstw.late%0d.ready", c), {31'd0, req_ready}, 32'd1);
      chk($sformatf("rstw.late%0d.mreq", c), {31'd0, mem_req}, 32'd0);
      @(negedge clk);
    end
    run_vec(vt[2], "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
